// File: rtl/nx_fifo_rr_sched.sv
// nx_fifo_rr_sched: round-robin read scheduler draining a bank of show-ahead
// FIFOs into a single registered valid/ready output stream. One pop per cycle
// at most, never from an empty FIFO, with each grant capped at BURST pops.
module nx_fifo_rr_sched #(
  parameter int N_FIFO = 4,
  parameter int WIDTH  = 128,
  parameter int BURST  = 4,
  parameter int SRC_W  = $clog2(N_FIFO)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic [N_FIFO-1:0]       fifo_empty,
  input  logic [N_FIFO*WIDTH-1:0] fifo_rdata,
  output logic [N_FIFO-1:0]       fifo_ren,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SRC_W-1:0]        out_src,
  output logic                    busy
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  // Burst counter sized for the largest legal BURST (255).
  localparam int              CNT_W = 8;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST - 1);
  localparam logic [SRC_W-1:0] TOP  = SRC_W'(N_FIFO - 1);

  logic [0:0]       state_q, state_d;
  logic [SRC_W-1:0] ptr_q, ptr_d;
  logic [SRC_W-1:0] gnt_q, gnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             vld_q, vld_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SRC_W-1:0] src_q, src_d;

  logic             load;
  logic             pop;
  logic             any_ne;
  logic             found;
  logic [SRC_W-1:0] cand;
  logic [SRC_W-1:0] next_idx;
  logic [SRC_W-1:0] gnt_inc;

  assign load    = !vld_q || out_ready;
  assign any_ne  = (~fifo_empty) != '0;
  // Explicit wrap so non-power-of-two bank sizes index correctly.
  assign gnt_inc = (gnt_q == TOP) ? '0 : gnt_q + 1'b1;

  // First non-empty FIFO scanning upward from ptr with modulo wrap.
  always_comb begin
    next_idx = ptr_q;
    found    = 1'b0;
    cand     = ptr_q;
    for (int i = 0; i < N_FIFO; i++) begin
      cand = SRC_W'((int'(ptr_q) + i) % N_FIFO);
      if (!found && !fifo_empty[cand]) begin
        next_idx = cand;
        found    = 1'b1;
      end
    end
  end

  // Grant FSM, burst accounting and output-register next state.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    data_d  = data_q;
    src_d   = src_q;
    pop     = 1'b0;
    if (clear) begin
      // ptr is deliberately kept so fairness survives a flush.
      state_d = IDLE;
      cnt_d   = '0;
      vld_d   = 1'b0;
    end else begin
      if (vld_q && out_ready) begin
        vld_d = 1'b0;
      end
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (any_ne) begin
            gnt_d   = next_idx;
            state_d = GRANT;
          end
        end
        default: begin
          if (load) begin
            if (!fifo_empty[gnt_q]) begin
              pop    = 1'b1;
              cnt_d  = cnt_q + 1'b1;
              vld_d  = 1'b1;
              data_d = fifo_rdata[gnt_q*WIDTH +: WIDTH];
              src_d  = gnt_q;
              if (cnt_q == LAST) begin
                ptr_d   = gnt_inc;
                state_d = IDLE;
              end
            end else begin
              // Holder ran dry: end the grant early, count does not carry over.
              ptr_d   = gnt_inc;
              state_d = IDLE;
            end
          end
        end
      endcase
    end
  end

  // One-hot read enable for the granted FIFO on a pop cycle.
  always_comb begin
    fifo_ren = '0;
    if (pop) begin
      fifo_ren[gnt_q] = 1'b1;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      src_q   <= src_d;
    end
  end

  assign out_valid = vld_q;
  assign out_data  = data_q;
  assign out_src   = src_q;
  assign busy      = (state_q == GRANT) || vld_q;

  a_ren_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(fifo_ren));
  a_ren_not_empty: assert property (@(posedge clk) disable iff (!rst_n)
    (fifo_ren & fifo_empty) == '0);

endmodule

// File: tb/tb_nx_fifo_rr_sched.sv
// Bench for nx_fifo_rr_sched: behavioural show-ahead FIFO bank, directed
// stimulus with a scoreboard of expected output words, and a monitor that
// compares each accepted output word against the scoreboard.
module tb_nx_fifo_rr_sched;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           clear = 1'b0;
  logic           out_ready = 1'b0;
  logic [N-1:0]   fifo_empty;
  logic [N*W-1:0] fifo_rdata;
  logic [N-1:0]   fifo_ren;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_src;
  logic           busy;

  int checks = 0;
  int failures = 0;

  logic [W-1:0]  mem [N][32];
  int            wp [N];
  int            rp [N];
  logic [N-1:0]  ren_s;
  logic [W-1:0]  exp_d [$];
  logic [SW-1:0] exp_s [$];

  always #5 clk = ~clk;

  nx_fifo_rr_sched #(.N_FIFO(N), .WIDTH(W), .BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata), .fifo_ren(fifo_ren),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_src(out_src), .busy(busy)
  );

  function automatic logic [W-1:0] mk(int s, int k);
    return W'(32'hA000_0000 + s * 256 + k);
  endfunction

  task automatic upd();
    for (int i = 0; i < N; i++) begin
      fifo_empty[i] = (wp[i] == rp[i]);
      fifo_rdata[i*W +: W] = mem[i][rp[i][4:0]];
    end
  endtask

  task automatic push(int s, int k);
    mem[s][wp[s][4:0]] = mk(s, k);
    wp[s]++;
    upd();
  endtask

  task automatic ex(int s, int k);
    exp_d.push_back(mk(s, k));
    exp_s.push_back(SW'(s));
  endtask

  task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic cyc(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drain(string nm, int lim);
    int c;
    c = 0;
    while (exp_d.size() != 0 && c < lim) begin
      cyc();
      c++;
    end
    checks++;
    if (exp_d.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: %0d words outstanding, expected 0", nm, exp_d.size());
      exp_d.delete();
      exp_s.delete();
    end
    cyc(3);
    chk({nm, "_busy_idle"}, W'(busy), '0);
  endtask

  // FIFO bank model: pop on the edge where ren was high, update just after.
  always @(posedge clk) begin
    ren_s = fifo_ren;
    #1;
    for (int i = 0; i < N; i++) begin
      if (ren_s[i]) rp[i]++;
    end
    upd();
  end

  // Monitor: every accepted output word must match the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_d.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word: got src=%0d data=%0h expected none", out_src, out_data);
      end else begin
        chk("out_data", out_data, exp_d.pop_front());
        chk("out_src", W'(out_src), W'(exp_s.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      wp[i] = 0;
      rp[i] = 0;
    end
    upd();
    cyc(2);
    chk("rst_out_valid", W'(out_valid), '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_src", W'(out_src), '0);
    chk("rst_busy", W'(busy), '0);
    chk("rst_ren", W'(fifo_ren), '0);
    rst_n = 1'b1;
    cyc();

    // Single source: three words from FIFO1.
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      push(1, k);
      ex(1, k);
    end
    cyc();
    chk("t1_ren_c1", W'(fifo_ren), W'(4'b0010));
    chk("t1_vld_c1", W'(out_valid), '0);
    cyc();
    chk("t1_ren_c2", W'(fifo_ren), W'(4'b0010));
    chk("t1_vld_c2", W'(out_valid), 1);
    cyc();
    chk("t1_ren_c3", W'(fifo_ren), W'(4'b0010));
    cyc();
    chk("t1_ren_c4", W'(fifo_ren), '0);
    chk("t1_vld_c4", W'(out_valid), 1);
    cyc();
    chk("t1_busy_c5", W'(busy), '0);
    chk("t1_vld_c5", W'(out_valid), '0);
    drain("t1", 10);

    // Four full FIFOs, six words each, bursts of four.
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    for (int s = 0; s < N; s++)
      for (int k = 0; k < 6; k++) push(s, k);
    for (int s = 0; s < N; s++)
      for (int k = 0; k < 4; k++) ex(s, k);
    for (int s = 0; s < N; s++)
      for (int k = 4; k < 6; k++) ex(s, k);
    drain("t2", 200);

    // Backpressure mid-burst on FIFO2.
    for (int k = 10; k < 14; k++) begin
      push(2, k);
      ex(2, k);
    end
    cyc(3);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t3_hold_data", out_data, mk(2, 11));
      chk("t3_hold_src", W'(out_src), 2);
      chk("t3_hold_ren", W'(fifo_ren), '0);
      chk("t3_hold_vld", W'(out_valid), 1);
    end
    out_ready = 1'b1;
    drain("t3", 50);

    // Wrap and skip: ptr sits at 3, FIFOs 0 and 2 non-empty.
    push(0, 20);
    push(2, 21);
    ex(0, 20);
    ex(2, 21);
    drain("t4", 50);

    // Synchronous clear mid-burst with burst count at two.
    for (int k = 30; k < 36; k++) push(1, k);
    ex(1, 30);
    cyc(3);
    out_ready = 1'b0;
    clear = 1'b1;
    push(0, 36);
    push(3, 37);
    #1;
    chk("t5_ren_clear", W'(fifo_ren), '0);
    cyc();
    chk("t5_vld_after", W'(out_valid), '0);
    chk("t5_busy_after", W'(busy), '0);
    clear = 1'b0;
    out_ready = 1'b1;
    ex(3, 37);
    ex(0, 36);
    for (int k = 32; k < 36; k++) ex(1, k);
    drain("t5", 100);

    // Asynchronous reset between edges while a word is presented.
    for (int k = 40; k < 44; k++) push(2, k);
    cyc(2);
    chk("t6_vld_before", W'(out_valid), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_vld", W'(out_valid), '0);
    chk("t6_rst_data", out_data, '0);
    chk("t6_rst_src", W'(out_src), '0);
    chk("t6_rst_busy", W'(busy), '0);
    chk("t6_rst_ren", W'(fifo_ren), '0);
    push(0, 44);
    cyc();
    rst_n = 1'b1;
    ex(0, 44);
    for (int k = 41; k < 44; k++) ex(2, k);
    drain("t6", 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
